// File: rtl/bsg_wormhole_loopback_client.sv
// bsg_wormhole_loopback_client
// Packet-aware loopback/sink endpoint for wormhole network tests. Each of
// num_nets_p independent links runs input FIFO -> header/body FSM -> output
// FIFO. In loopback mode packets are returned with the header cord replaced
// by dest_cord_i; in sink mode they are consumed. Completed packets are
// counted per net.
//
// Ports
//   clk_i          single clock
//   reset_i        synchronous, active-high reset
//   dest_cord_i    cord written into every looped-back header
//   loopback_en_i  per net: 1 = loopback, 0 = sink (sampled at header consume)
//   link_i         per net {v, data[flit_width_p-1:0], ready_and_rev}
//   link_o         per net {v, data[flit_width_p-1:0], ready_and_rev}
//   pkt_count_o    per net count of fully consumed packets (wraps)
//   busy_o         per net: mid-packet or any FIFO non-empty

// Small two-pointer FIFO; ready_o is simply "not full".
module bsg_wormhole_loopback_client_fifo #(
  parameter int unsigned width_p = 16,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic                    enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign ready_o = (cnt_r != cnt_width_lp'(els_p));
  assign v_o     = (cnt_r != '0);
  assign data_o  = mem_r[rd_ptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointer and occupancy state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (enq) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_next(rd_ptr_r);
      if (enq && !deq)      cnt_r <= cnt_r + cnt_width_lp'(1);
      else if (!enq && deq) cnt_r <= cnt_r - cnt_width_lp'(1);
    end
  end

  // Storage needs no reset; occupancy gates visibility
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end
endmodule

module bsg_wormhole_loopback_client #(
  parameter int unsigned flit_width_p = 16,
  parameter int unsigned dims_p       = 2,
  parameter int unsigned cord_markers_pos_p [dims_p:0] = '{5, 4, 0},
  parameter int unsigned len_width_p  = 3,
  parameter int unsigned num_nets_p   = 2,
  parameter int unsigned fifo_els_p   = 2,
  parameter int unsigned ctr_width_p  = 16,
  localparam int unsigned cord_width_lp = cord_markers_pos_p[dims_p],
  localparam int unsigned link_width_lp = flit_width_p + 2
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [cord_width_lp-1:0]                 dest_cord_i,
  input  logic [num_nets_p-1:0]                    loopback_en_i,
  input  logic [num_nets_p-1:0][link_width_lp-1:0] link_i,
  output logic [num_nets_p-1:0][link_width_lp-1:0] link_o,
  output logic [num_nets_p-1:0][ctr_width_p-1:0]   pkt_count_o,
  output logic [num_nets_p-1:0]                    busy_o
);
  typedef enum logic {HDR = 1'b0, BODY = 1'b1} state_e;

  for (genvar i = 0; i < num_nets_p; i++) begin : g_net
    state_e                  state_r, state_n;
    logic [len_width_p-1:0]  rem_r, rem_n;
    logic                    mode_r, mode_n;
    logic [ctr_width_p-1:0]  cnt_r;
    logic                    cnt_inc;

    logic                    in_ready, in_v, in_yumi;
    logic [flit_width_p-1:0] in_data;
    logic                    out_ready, out_enq, out_v;
    logic [flit_width_p-1:0] out_data, out_data_lo;
    logic [len_width_p-1:0]  hdr_len;

    assign hdr_len = in_data[cord_width_lp +: len_width_p];

    bsg_wormhole_loopback_client_fifo #(
      .width_p(flit_width_p), .els_p(fifo_els_p)
    ) u_in_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (link_i[i][link_width_lp-1]),
      .ready_o(in_ready),
      .data_i (link_i[i][link_width_lp-2:1]),
      .v_o    (in_v),
      .data_o (in_data),
      .yumi_i (in_yumi)
    );

    bsg_wormhole_loopback_client_fifo #(
      .width_p(flit_width_p), .els_p(fifo_els_p)
    ) u_out_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (out_enq),
      .ready_o(out_ready),
      .data_i (out_data),
      .v_o    (out_v),
      .data_o (out_data_lo),
      .yumi_i (link_i[i][0])
    );

    // FSM state, remaining-body counter, latched mode and packet counter
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_r <= HDR;
        rem_r   <= '0;
        mode_r  <= 1'b0;
        cnt_r   <= '0;
      end else begin
        state_r <= state_n;
        rem_r   <= rem_n;
        mode_r  <= mode_n;
        if (cnt_inc) cnt_r <= cnt_r + ctr_width_p'(1);
      end
    end

    // Header/body sequencing; sink mode consumes without waiting on the output FIFO
    always_comb begin
      state_n  = state_r;
      rem_n    = rem_r;
      mode_n   = mode_r;
      in_yumi  = 1'b0;
      out_enq  = 1'b0;
      out_data = in_data;
      cnt_inc  = 1'b0;
      unique case (state_r)
        HDR: begin
          if (in_v && (!loopback_en_i[i] || out_ready)) begin
            in_yumi  = 1'b1;
            out_enq  = loopback_en_i[i];
            out_data = {in_data[flit_width_p-1:cord_width_lp], dest_cord_i};
            mode_n   = loopback_en_i[i];
            rem_n    = hdr_len;
            if (hdr_len == '0) cnt_inc = 1'b1;
            else               state_n = BODY;
          end
        end
        BODY: begin
          if (in_v && (!mode_r || out_ready)) begin
            in_yumi = 1'b1;
            out_enq = mode_r;
            rem_n   = rem_r - len_width_p'(1);
            if (rem_r == len_width_p'(1)) begin
              cnt_inc = 1'b1;
              state_n = HDR;
            end
          end
        end
        default: state_n = HDR;
      endcase
    end

    assign link_o[i]      = {out_v, out_data_lo, in_ready};
    assign pkt_count_o[i] = cnt_r;
    assign busy_o[i]      = (state_r == BODY) | in_v | out_v;
  end
endmodule

// File: doc/bsg_wormhole_loopback_client.md
# bsg_wormhole_loopback_client

Parametrised, packet-aware loopback/sink client for wormhole network testbenches. It terminates `num_nets_p` independent ready/valid links. It tracks multi-flit packets with a per-net header/body FSM. In loopback mode it returns each packet with only the header cord rewritten; in sink mode it consumes the packet. It sits at a router's local port in `bsg_wormhole_network` tests and reports per-net received-packet counts for scoreboarding.

## Interface
- `flit_width_p`, "inv": flit data width.
- `dims_p`, 2: number of routing dimensions.
- `cord_markers_pos_p[dims_p:0]`, '{5,4,0}: cord field boundaries; `cord_width_lp = cord_markers_pos_p[dims_p]`.
- `len_width_p`, "inv": header length field width; len = number of body flits after the header.
- `num_nets_p`, 2: number of independent links/clients.
- `fifo_els_p`, 2: input and output FIFO depth per net; must be >=2.
- `ctr_width_p`, 16: packet counter width.
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `dest_cord_i`  in  cord_width_lp  cord written into every looped-back header.
- `loopback_en_i`  in  num_nets_p  per net: 1 = loopback, 0 = sink; sampled only at header acceptance.
- `link_i`  in  num_nets_p x bsg_ready_and_link_sif_width(flit_width_p)  incoming v/data, and ready_and_rev for outgoing flits.
- `link_o`  out  num_nets_p x same  outgoing v/data, and ready_and_rev for incoming flits.
- `pkt_count_o`  out  num_nets_p x ctr_width_p  packets fully consumed per net.
- `busy_o`  out  num_nets_p  net is mid-packet (FSM in BODY) or either FIFO is non-empty.

## Operation
- Header flit: cord at bits [cord_width_lp-1:0]; len at [cord_width_lp+len_width_p-1:cord_width_lp]; the remaining bits are data.
- Per net: input FIFO -> FSM -> output FIFO (both `bsg_fifo_1r1w_small`, `fifo_els_p` deep).
- Input acceptance: `link_o.ready_and_rev = ~in_fifo_full`. A flit is enqueued when `v & ready_and_rev`.
- FSM state HDR, consuming the flit at the head of the input FIFO:
  - Latch `mode = loopback_en_i[i]` and `rem = len`.
  - If len==0: count the packet and stay in HDR.
  - Otherwise go to BODY.
- FSM state BODY, each consumed flit:
  - `rem` decrements.
  - When the flit is consumed with rem==1: count the packet and go to HDR.
- Consume condition:
  - Loopback mode: `in_v & out_fifo_ready`.
  - Sink mode: `in_v` alone; nothing is enqueued to the output FIFO.
- Loopback output: the header goes out with its cord replaced by `dest_cord_i`; len and data are unchanged. Body flits go out bit-identical.
- `dest_cord_i` is sampled at the cycle the header is enqueued to the output FIFO.
- `pkt_count_o[i]` increments by 1 on consumption of a packet's final flit, in both modes. It wraps modulo 2^ctr_width_p.
- Nets are fully independent; no shared state or arbitration.
- Outgoing flit dequeue: `link_o.v & link_i.ready_and_rev`.

## Timing
- Reset values:
  - FSM = HDR, rem = 0, mode = 0.
  - FIFOs empty; `link_o.v = 0`.
  - `pkt_count_o = 0`, `busy_o = 0`.
- `link_o.ready_and_rev = 1` in and after reset. Flits must not be presented while `reset_i` is high; any such flits are discarded.
- Latency, no backpressure: a flit accepted at edge N is valid on `link_o` from cycle N+2.
- Throughput: 1 flit/cycle/net sustained.
- Backpressure: with `link_i.ready_and_rev = 0`, the output FIFO fills, then the input FIFO fills, then incoming ready drops. At most 2*`fifo_els_p` flits are buffered. No flit is lost or duplicated.
- `loopback_en_i` changes mid-packet have no effect until the next header is consumed.
- len = 2^len_width_p-1: rem counts down correctly; no overflow.
- Reset asserted mid-packet: FIFO contents are dropped and FSM returns to HDR on the next edge. Counters clear.
- A counter increment and a reset in the same cycle: reset wins.

## Test plan
- Loopback, single-flit packet: net0 header len=0, cord=3, dest_cord_i=9, loopback_en=1 -> one flit out at N+2 with cord=9, len=0, data unchanged; pkt_count_o[0]=1.
- Multi-flit: header len=3 + 3 body flits back-to-back -> 4 flits out on consecutive cycles, header cord rewritten, bodies unchanged even when a body's low bits mimic a header; count=1.
- Sink mode: loopback_en=0, packet len=2 -> ready stays 1, `link_o.v` never asserts, count=1; raising loopback_en mid-packet has no effect on that packet.
- Backpressure: `link_i.ready_and_rev=0` with fifo_els_p=2, stream 10 flits -> incoming ready drops after 4 accepted. Releasing it delivers all 10 in order.
- Independence: both nets streaming, net1 stalled downstream -> net0 keeps 1 flit/cycle throughput.
- Reset mid-packet: after header len=5 and 2 bodies, assert reset_i for 1 cycle -> outputs return to reset values. A following len=0 packet loops back correctly with count=1.
